relu_maxpool: RTL and testbench
===============================

# relu_maxpool

Downstream stage of the convolution layer: consumes one full row of signed convolution results per handshake and applies ReLU, 2x2 max-pooling (stride 2) and requantisation back to pixel width. It emits the pooled feature map as a serial stream of unsigned pixels with valid/ready flow control. A 28x28 input frame becomes a 14x14 output frame, which feeds the next convolution layer or the classifier.

## Interface
- N, 7: pixel MSB index; output pixels are N+1 bits, input results are 2N+2 bits.
- im, 28: input row length and rows per frame; must be even.
- SHIFT, 4: arithmetic right shift applied before saturation.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_row  in  im x (2N+2)  one convolution output row, two's complement, index 0 = leftmost column.
- in_valid  in  1  in_row holds a valid row.
- in_ready  out  1  block accepts a row this cycle.
- out_data  out  N+1  pooled, requantised pixel (unsigned).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_last  out  1  high with the final pixel of a frame (pixel im/2 x im/2).
- frame_done  out  1  one-cycle pulse the cycle after the out_last beat is accepted.

## Operation
- The input row is accepted when in_valid && in_ready; an output beat is accepted when out_valid && out_ready.
- relu(x) = (x < 0) ? 0 : x. The horizontal pair is h[j] = max(relu(in_row[2j]), relu(in_row[2j+1])) for j = 0..im/2-1.
- Storage: buffer pool[0..im/2-1], each 2N+2 bits, non-negative. Counters: col (0..im/2-1) and pair_row (0..im/2-1).
- FSM:
  - S_EVEN: in_ready=1. On accept, pool[j] <= h[j] and go to S_ODD.
  - S_ODD: in_ready=1. On accept, pool[j] <= max(pool[j], h[j]), col <= 0, and go to S_EMIT.
  - S_EMIT: in_ready=0, out_valid=1, and out_data = sat(pool[col] >> SHIFT). sat clamps to 2^(N+1)-1 (255 for N=7).
    - On accept with col < im/2-1: col++.
    - On accept with col = im/2-1: go to S_EVEN. If pair_row = im/2-1, pair_row <= 0 and frame_done pulses; otherwise pair_row++.
- out_last = (state==S_EMIT) && (col==im/2-1) && (pair_row==im/2-1).
- Comparisons are done at full 2N+2 width. No rounding on the shift (truncation).
- The block does not look at in_row when in_ready=0. Rows presented during S_EMIT are held off, not dropped.

## Timing
- Reset: the FSM goes to S_EVEN and col, pair_row, out_valid, out_data, out_last and frame_done are 0. in_ready is 1 in the first cycle after reset. The pool contents are don't-care.
- Reset has priority over every handshake. Asserting it mid-row or mid-emit discards the partial pair, and out_valid drops in the next cycle.
- Latency: accepting the odd row at edge t gives out_valid=1 with pixel 0 after edge t. Without backpressure, 14 beats follow on consecutive cycles.
- The even-row accept has no output.
- Back-to-back throughput: 2 rows in 2 cycles, then im/2 output cycles, then in_ready rises again in the cycle after the last beat.
- Under backpressure (out_ready=0), out_data, out_last and col hold stable. out_valid is never withdrawn once raised until it is accepted.
- frame_done is high for exactly one cycle, the cycle after the accepted out_last beat. It is registered and independent of out_ready.
- in_valid held high across S_EMIT: the row is accepted in the first S_EVEN cycle.

## Test plan
- Row0 all 16, row1 all 32, out_ready=1 → after the row1 accept, 14 consecutive beats of out_data=2, out_last=0, then in_ready=1.
- Row0 all -100, row1 all -5 → 14 beats of 0 (ReLU clamps negatives before the max).
- Row0 in[2j]=16*j with odd columns 0; row1 in[2j+1]=16*(j+1) with even columns 0 → beat j = j+1. Row of 0x7FFF → 255 (saturation).
- Backpressure: out_ready low for 5 cycles at col=6 → out_data holds value 6 and in_ready stays 0. All 14 beats arrive in order with none lost or duplicated.
- Full frame of 28 rows with random values against a golden model → 196 beats that match, out_last only on beat 196, one frame_done pulse, and pair_row wraps to 0.
- Reset asserted during S_EMIT at col=5 → next cycle out_valid=0 and in_ready=1. The next two rows produce a fresh 14-beat row with pair_row=0.

Source files
------------

// File: rtl/relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool
// Purpose  : ReLU + 2x2/stride-2 max-pool + requantise, one conv row per
//            handshake in, serial unsigned pooled pixels out (valid/ready).
// Revision : 1.0  initial release
// ============================================================================
module relu_maxpool #(
    parameter int N     = 7,
    parameter int im    = 28,
    parameter int SHIFT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [im-1:0][2*N+1:0]      in_row,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [N:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        frame_done
);

    localparam int W    = 2 * N + 2;
    localparam int HALF = im / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] C_LAST     = CW'(HALF - 1);
    localparam logic [W-1:0]  C_PIX_MAX  = W'({(N + 1){1'b1}});

    typedef enum logic [1:0] {
        S_EVEN = 2'd0,
        S_ODD  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                    r_state;
    logic [CW-1:0]             r_col;
    logic [CW-1:0]             r_pair_row;
    logic [HALF-1:0][W-1:0]    r_pool;
    logic                      r_out_valid;
    logic [N:0]                r_out_data;
    logic                      r_out_last;
    logic                      r_frame_done;

    logic [HALF-1:0][W-1:0]    w_h;
    logic [HALF-1:0][W-1:0]    w_merged;
    logic [CW-1:0]             w_col_nxt;
    logic                      w_row_acc;

    function automatic logic [N:0] sat(input logic [W-1:0] v);
        logic [W-1:0] s;
        s = v >> SHIFT;
        return (s > C_PIX_MAX) ? '1 : s[N:0];
    endfunction

    // After ReLU every operand is non-negative, so unsigned compares are exact.
    for (genvar j = 0; j < HALF; j++) begin : g_pair
        logic [W-1:0] w_lo;
        logic [W-1:0] w_hi;
        assign w_lo        = in_row[2*j][W-1]   ? '0 : in_row[2*j];
        assign w_hi        = in_row[2*j+1][W-1] ? '0 : in_row[2*j+1];
        assign w_h[j]      = (w_hi > w_lo) ? w_hi : w_lo;
        assign w_merged[j] = (w_h[j] > r_pool[j]) ? w_h[j] : r_pool[j];
    end

    assign in_ready   = (r_state != S_EMIT);
    assign w_row_acc  = in_valid && in_ready;
    assign w_col_nxt  = r_col + CW'(1);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;

    // Pool contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (!reset && w_row_acc) begin
            if (r_state == S_EVEN) begin
                r_pool <= w_h;
            end else begin
                r_pool <= w_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_EVEN;
            r_col        <= '0;
            r_pair_row   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_EVEN: begin
                    if (in_valid) begin
                        r_state <= S_ODD;
                    end
                end
                S_ODD: begin
                    // Output registers are loaded from the merged value so
                    // pixel 0 is presented in the very next cycle.
                    if (in_valid) begin
                        r_state     <= S_EMIT;
                        r_col       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= sat(w_merged[0]);
                        r_out_last  <= (C_LAST == '0) && (r_pair_row == C_LAST);
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (r_col != C_LAST) begin
                            r_col      <= w_col_nxt;
                            r_out_data <= sat(r_pool[w_col_nxt]);
                            r_out_last <= (w_col_nxt == C_LAST) && (r_pair_row == C_LAST);
                        end else begin
                            r_state     <= S_EVEN;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (r_pair_row == C_LAST) begin
                                r_pair_row   <= '0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_pair_row <= r_pair_row + CW'(1);
                            end
                        end
                    end
                end
                default: r_state <= S_EVEN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_maxpool
// Purpose  : Scoreboard bench for relu_maxpool (directed rows + random frame).
// Revision : 1.0  initial release
// ============================================================================
module tb_relu_maxpool;

    localparam int N     = 7;
    localparam int IM    = 28;
    localparam int SHIFT = 4;
    localparam int W     = 2 * N + 2;
    localparam int HALF  = IM / 2;

    typedef logic [IM-1:0][W-1:0] row_t;
    typedef logic [N:0]           pix_t;
    typedef struct packed {
        logic [N:0] data;
        logic       last;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    row_t  in_row;
    logic  in_valid;
    logic  in_ready;
    pix_t  out_data;
    logic  out_valid;
    logic  out_ready;
    logic  out_last;
    logic  frame_done;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_fd     = 0;
    int    tb_pr    = 0;
    logic  exp_fd   = 1'b0;

    relu_maxpool #(.N(N), .im(IM), .SHIFT(SHIFT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_row     (in_row),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: pops one expected beat per accepted output handshake.
    always @(negedge clk) begin
        exp_t e;
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        if (frame_done) n_fd++;
        exp_fd = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("beat_data", 32'(out_data), 32'(e.data));
                chk("beat_last", 32'(out_last), 32'(e.last));
                exp_fd = e.last;
            end
        end
    end

    function automatic pix_t model(input row_t a, input row_t b, input int j);
        int v[4];
        int m;
        v[0] = int'($signed(a[2*j]));
        v[1] = int'($signed(a[2*j+1]));
        v[2] = int'($signed(b[2*j]));
        v[3] = int'($signed(b[2*j+1]));
        m = 0;
        for (int k = 0; k < 4; k++) if (v[k] > m) m = v[k];
        m = m >>> SHIFT;
        if (m > 255) m = 255;
        return pix_t'(m);
    endfunction

    task automatic send_row(input row_t r);
        int t;
        in_row   = r;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pair(input row_t r0, input row_t r1, input pix_t e[HALF]);
        for (int j = 0; j < HALF; j++) begin
            sb.push_back('{data: e[j], last: (j == HALF - 1) && (tb_pr == HALF - 1)});
        end
        tb_pr = (tb_pr == HALF - 1) ? 0 : tb_pr + 1;
        send_row(r0);
        send_row(r1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("drain_left", 32'(sb.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tb_pr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r0, r1;
        pix_t e[HALF];

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready",   32'(in_ready),   32'(1));
        chk("rst_out_valid",  32'(out_valid),  32'(0));
        chk("rst_out_data",   32'(out_data),   32'(0));
        chk("rst_out_last",   32'(out_last),   32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));

        // 16/32 -> 32>>4 = 2
        for (int c = 0; c < IM; c++) begin r0[c] = 16'd16; r1[c] = 16'd32; end
        for (int j = 0; j < HALF; j++) e[j] = 8'd2;
        send_pair(r0, r1, e);

        // all negative -> 0
        for (int c = 0; c < IM; c++) begin r0[c] = -16'sd100; r1[c] = -16'sd5; end
        for (int j = 0; j < HALF; j++) e[j] = 8'd0;
        send_pair(r0, r1, e);

        // ramp: max(16j, 16(j+1)) >> 4 = j+1
        for (int j = 0; j < HALF; j++) begin
            r0[2*j] = 16'(16 * j);      r0[2*j+1] = 16'd0;
            r1[2*j] = 16'd0;            r1[2*j+1] = 16'(16 * (j + 1));
            e[j]    = 8'(j + 1);
        end
        send_pair(r0, r1, e);

        // 0x7FFF >> 4 = 0x7FF saturates to 255
        for (int c = 0; c < IM; c++) begin r0[c] = 16'h7FFF; r1[c] = 16'h7FFF; end
        for (int j = 0; j < HALF; j++) e[j] = 8'd255;
        send_pair(r0, r1, e);

        // backpressure at col 6; pixel j = j
        for (int j = 0; j < HALF; j++) begin
            r0[2*j] = 16'(16 * j); r0[2*j+1] = 16'd0;
            r1[2*j] = 16'd0;       r1[2*j+1] = 16'd0;
            e[j]    = 8'(j);
        end
        send_pair(r0, r1, e);
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_data",  32'(out_data),  32'(6));
            chk("bp_out_valid", 32'(out_valid), 32'(1));
            chk("bp_in_ready",  32'(in_ready),  32'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // reset during emit at col 5
        send_pair(r0, r1, e);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_in_ready",  32'(in_ready),  32'(1));
        chk("mid_rst_left",      32'(sb.size()), 32'(9));
        sb.delete();
        tb_pr     = 0;
        out_ready = 1'b1;
        for (int j = 0; j < HALF; j++) e[j] = 8'(j);
        send_pair(r0, r1, e);
        drain();

        // full random frame against the golden model
        pulse_reset();
        for (int p = 0; p < HALF; p++) begin
            for (int c = 0; c < IM; c++) begin
                r0[c] = 16'($urandom);
                r1[c] = 16'($urandom_range(0, 8191));
            end
            for (int j = 0; j < HALF; j++) e[j] = model(r0, r1, j);
            send_pair(r0, r1, e);
        end
        drain();

        // pair_row has wrapped: this row must not raise out_last
        for (int c = 0; c < IM; c++) begin r0[c] = 16'd48; r1[c] = -16'sd1; end
        for (int j = 0; j < HALF; j++) e[j] = 8'd3;
        send_pair(r0, r1, e);
        drain();
        repeat (2) @(posedge clk);

        chk("frame_done_count", 32'(n_fd), 32'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
